ctrl_seq: RTL and testbench
===========================

CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 Clk  input  1  rising-edge clock, sole clock domain.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 Instruction  input  9  instruction word: [8:5] opcode, [4:0] immediate/register field.
REQ-004 InstrValid  input  1  Instruction valid from fetch.
REQ-005 InstrReady  output  1  ctrl_seq accepts Instruction this cycle.
REQ-006 Zero  input  1  ALU zero flag, combinational from ALU Out.
REQ-007 AluOp  output  4  ALU opcode (op_mne encoding).
REQ-008 Immediate  output  5  immediate to ALU.
REQ-009 RaddrB  output  3  register-file read address for ALU InputB; InputA is always R0.
REQ-010 RegWrEn  output  1  one-cycle write strobe; destination is always R0.
REQ-011 PcEn  output  1  one-cycle PC advance strobe.
REQ-012 BranchTaken  output  1  qualifies PcEn: PC += sign-extended BranchOffset instead of +1.
REQ-013 BranchOffset  output  5  branch displacement, two's complement.
REQ-014 Halted  output  1  high while in HALT.
REQ-015 IllegalOp  output  1  sticky error flag.

Function
REQ-016 FSM states SHALL be FETCH, DECODE, EXEC, WB, HALT, ERR.
REQ-017 In FETCH: InstrReady=1; if InstrValid=1, latch Instruction and go to DECODE; else stay.
REQ-018 Instruction SHALL be captured only on the InstrValid&&InstrReady cycle; InstrReady=0 in all other states.
REQ-019 DECODE (1 cycle): register AluOp, Immediate=Instr[4:0], RaddrB=Instr[2:0]; opcodes 0-6 -> EXEC; 7 (BNZ) -> EXEC with AluOp=ADD, Immediate=0; 15 -> HALT; 8-14 -> ERR.
REQ-020 Opcodes 0-6 SHALL map 1:1 to ADD, LSL, LSR, XOR, SNE, SEQ, MSK.
REQ-021 EXEC (1 cycle): AluOp/Immediate/RaddrB held stable; Zero sampled at end of EXEC.
REQ-022 ALU ops: EXEC -> WB; WB asserts RegWrEn=1 and PcEn=1 for exactly one cycle, BranchTaken=0, then FETCH.
REQ-023 BNZ: no WB and RegWrEn stays 0; cycle after EXEC asserts PcEn=1; BranchTaken=~Zero_sampled; BranchOffset=Instr[4:0]; then FETCH.
REQ-024 Latency: ALU op = 4 cycles accept-to-accept; BNZ = 4 cycles (accept, DECODE, EXEC, PC cycle).
REQ-025 RegWrEn, PcEn and BranchTaken SHALL be mutually consistent: BranchTaken=1 only when PcEn=1; RegWrEn=1 never on a branch.
REQ-026 HALT: Halted=1, all strobes 0, InstrReady=0; exit only by Reset.
REQ-027 ERR: IllegalOp=1 (sticky), strobes 0, InstrReady=0; exit only by Reset.
REQ-028 All outputs SHALL be registered except InstrReady (decoded from state register).

Reset
REQ-029 Reset asserted SHALL force state=FETCH, AluOp=ADD, Immediate=0, RaddrB=0, BranchOffset=0, all strobes/flags=0, asynchronously.
REQ-030 Reset mid-instruction SHALL abort it: no RegWrEn/PcEn from the aborted instruction.
REQ-031 First acceptance possible on the first Clk edge after Reset deasserts.

Structure
REQ-032 State enum (ctrl_state) and opcode constants BNZ=7, HALT=15 SHALL live in package Definitions next to op_mne.
REQ-033 Single module, no sub-modules; decode as a pure function inside the module.

Verification
REQ-034 Reset, Instruction=0_0000_0101 (ADD #5) with InstrValid=1 -> DECODE/EXEC with AluOp=ADD, Immediate=5, RegWrEn=PcEn=1 in cycle 4, InstrReady=1 again in cycle 5.
REQ-035 BNZ offset -3 (Instruction=0111_11101) with Zero=0 -> PcEn=1, BranchTaken=1, BranchOffset=5'b11101, RegWrEn=0; repeat with Zero=1 -> BranchTaken=0.
REQ-036 Opcode 15 -> Halted=1 permanently, InstrReady=0 despite InstrValid=1; Reset clears Halted.
REQ-037 Opcode 9 -> IllegalOp=1, no strobes ever; stays until Reset.
REQ-038 Reset asserted during EXEC of XOR R3 -> no RegWrEn/PcEn, outputs at reset values immediately, FETCH after release.
REQ-039 InstrValid held low 10 cycles in FETCH -> no state change, all strobes 0; back-to-back valid instructions each accepted every 4 cycles.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// ============================================================================
// Module : Definitions (package)
// Brief  : Shared types and opcode constants for the ctrl_seq sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package Definitions;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        LSL = 4'd1,
        LSR = 4'd2,
        XOR = 4'd3,
        SNE = 4'd4,
        SEQ = 4'd5,
        MSK = 4'd6
    } op_mne;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        WB     = 3'd3,
        HALT   = 3'd4,
        ERR    = 3'd5
    } ctrl_state;

    localparam logic [3:0] c_OP_BNZ  = 4'd7;
    localparam logic [3:0] c_OP_HALT = 4'd15;

    typedef struct packed {
        op_mne     alu_op;
        logic [4:0] imm;
        logic [2:0] raddr;
        ctrl_state nxt;
    } dec_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_seq.sv
// ============================================================================
// Module : ctrl_seq
// Brief  : Fetch/decode/execute/writeback control sequencer for a tiny ALU core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_seq
    import Definitions::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [8:0] Instruction,
    input  logic       InstrValid,
    output logic       InstrReady,
    input  logic       Zero,
    output logic [3:0] AluOp,
    output logic [4:0] Immediate,
    output logic [2:0] RaddrB,
    output logic       RegWrEn,
    output logic       PcEn,
    output logic       BranchTaken,
    output logic [4:0] BranchOffset,
    output logic       Halted,
    output logic       IllegalOp
);

    function automatic dec_t f_decode(input logic [8:0] instr);
        dec_t d;
        d.alu_op = ADD;
        d.imm    = instr[4:0];
        d.raddr  = instr[2:0];
        d.nxt    = ERR;
        if (instr[8:5] <= 4'd6) begin
            d.alu_op = op_mne'(instr[8:5]);
            d.nxt    = EXEC;
        end else if (instr[8:5] == c_OP_BNZ) begin
            d.imm = 5'd0;
            d.nxt = EXEC;
        end else if (instr[8:5] == c_OP_HALT) begin
            d.nxt = HALT;
        end
        return d;
    endfunction

    ctrl_state  r_state;
    logic [8:0] r_instr;
    logic [3:0] r_alu_op;
    logic [4:0] r_imm;
    logic [2:0] r_raddr;
    logic       r_regwr;
    logic       r_pcen;
    logic       r_taken;
    logic [4:0] r_boff;
    logic       r_halted;
    logic       r_illegal;

    ctrl_state  w_next;
    dec_t       w_dec;
    logic       w_is_bnz;
    logic       w_accept;
    logic       w_regwr_nxt;
    logic       w_pcen_nxt;
    logic       w_taken_nxt;

    always_comb begin
        w_next      = r_state;
        w_dec       = f_decode(r_instr);
        w_is_bnz    = (r_instr[8:5] == c_OP_BNZ);
        w_accept    = (r_state == FETCH) && InstrValid;
        w_regwr_nxt = 1'b0;
        w_pcen_nxt  = 1'b0;
        w_taken_nxt = 1'b0;
        case (r_state)
            FETCH:   if (InstrValid) w_next = DECODE;
            DECODE:  w_next = w_dec.nxt;
            EXEC: begin
                // WB doubles as the PC-update cycle for BNZ, with no register write
                w_next      = WB;
                w_regwr_nxt = !w_is_bnz;
                w_pcen_nxt  = 1'b1;
                w_taken_nxt = w_is_bnz && !Zero;
            end
            WB:      w_next = FETCH;
            HALT:    w_next = HALT;
            ERR:     w_next = ERR;
            default: w_next = FETCH;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= FETCH;
            r_instr   <= 9'd0;
            r_alu_op  <= ADD;
            r_imm     <= 5'd0;
            r_raddr   <= 3'd0;
            r_regwr   <= 1'b0;
            r_pcen    <= 1'b0;
            r_taken   <= 1'b0;
            r_boff    <= 5'd0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_instr <= Instruction;
            end
            if (r_state == DECODE) begin
                r_alu_op <= w_dec.alu_op;
                r_imm    <= w_dec.imm;
                r_raddr  <= w_dec.raddr;
                if (w_is_bnz) begin
                    r_boff <= r_instr[4:0];
                end
            end
            r_regwr   <= w_regwr_nxt;
            r_pcen    <= w_pcen_nxt;
            r_taken   <= w_taken_nxt;
            r_halted  <= (w_next == HALT);
            r_illegal <= r_illegal || (w_next == ERR);
        end
    end

    assign InstrReady   = (r_state == FETCH);
    assign AluOp        = r_alu_op;
    assign Immediate    = r_imm;
    assign RaddrB       = r_raddr;
    assign RegWrEn      = r_regwr;
    assign PcEn         = r_pcen;
    assign BranchTaken  = r_taken;
    assign BranchOffset = r_boff;
    assign Halted       = r_halted;
    assign IllegalOp    = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_seq.sv
// ============================================================================
// Module : tb_ctrl_seq
// Brief  : Self-checking bench for ctrl_seq with a cycle-level reference model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ctrl_seq;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [8:0] Instruction;
    logic       InstrValid;
    logic       Zero;
    logic       InstrReady;
    logic [3:0] AluOp;
    logic [4:0] Immediate;
    logic [2:0] RaddrB;
    logic       RegWrEn;
    logic       PcEn;
    logic       BranchTaken;
    logic [4:0] BranchOffset;
    logic       Halted;
    logic       IllegalOp;

    int n_checks = 0;
    int n_fail   = 0;

    ctrl_seq dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Instruction  (Instruction),
        .InstrValid   (InstrValid),
        .InstrReady   (InstrReady),
        .Zero         (Zero),
        .AluOp        (AluOp),
        .Immediate    (Immediate),
        .RaddrB       (RaddrB),
        .RegWrEn      (RegWrEn),
        .PcEn         (PcEn),
        .BranchTaken  (BranchTaken),
        .BranchOffset (BranchOffset),
        .Halted       (Halted),
        .IllegalOp    (IllegalOp)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] alu;
        logic [4:0] imm;
        logic [2:0] rb;
        logic       regwr;
        logic       pcen;
        logic       taken;
        logic       is_br;
    } exp_t;

    // Expected EXEC-cycle fields and writeback-cycle strobes for opcodes 0..7.
    function automatic exp_t model(input logic [8:0] ins, input logic z);
        exp_t e;
        e.rb = ins[2:0];
        if (ins[8:5] == 4'd7) begin
            e.alu = 4'd0; e.imm = 5'd0; e.regwr = 1'b0; e.pcen = 1'b1;
            e.taken = ~z; e.is_br = 1'b1;
        end else begin
            e.alu = ins[8:5]; e.imm = ins[4:0]; e.regwr = 1'b1; e.pcen = 1'b1;
            e.taken = 1'b0; e.is_br = 1'b0;
        end
        return e;
    endfunction

    task automatic run_instr(input logic [8:0] ins, input logic z, input string tag);
        exp_t e;
        e = model(ins, z);
        @(negedge Clk);
        n_checks++;
        if ({InstrReady, RegWrEn, PcEn, BranchTaken} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s fetch: ready/regwr/pcen/taken got %b want 1000", tag,
                     {InstrReady, RegWrEn, PcEn, BranchTaken});
        end
        Instruction = ins;
        InstrValid  = 1'b1;
        @(posedge Clk); #1;
        InstrValid  = 1'b0;
        Instruction = 9'($urandom);
        @(negedge Clk);
        n_checks++;
        if ({InstrReady, RegWrEn, PcEn, BranchTaken} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s decode: ready/strobes got %b want 0000", tag,
                     {InstrReady, RegWrEn, PcEn, BranchTaken});
        end
        @(posedge Clk); #1;
        Zero = z;
        @(negedge Clk);
        n_checks++;
        if ({AluOp, Immediate, RaddrB} !== {e.alu, e.imm, e.rb}) begin
            n_fail++;
            $display("FAIL %s exec: alu/imm/rb got %0h/%0h/%0h want %0h/%0h/%0h", tag,
                     AluOp, Immediate, RaddrB, e.alu, e.imm, e.rb);
        end
        n_checks++;
        if ({InstrReady, RegWrEn, PcEn, BranchTaken} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s exec strobes: got %b want 0000", tag,
                     {InstrReady, RegWrEn, PcEn, BranchTaken});
        end
        @(posedge Clk); #1;
        Zero = 1'($urandom);
        @(negedge Clk);
        n_checks++;
        if ({InstrReady, RegWrEn, PcEn, BranchTaken} !== {1'b0, e.regwr, e.pcen, e.taken}) begin
            n_fail++;
            $display("FAIL %s wb: ready/regwr/pcen/taken got %b want %b", tag,
                     {InstrReady, RegWrEn, PcEn, BranchTaken}, {1'b0, e.regwr, e.pcen, e.taken});
        end
        if (e.is_br) begin
            n_checks++;
            if (BranchOffset !== ins[4:0]) begin
                n_fail++;
                $display("FAIL %s offset: got %b want %b", tag, BranchOffset, ins[4:0]);
            end
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; InstrValid = 1'b0; Instruction = 9'd0; Zero = 1'b0;
        repeat (2) @(negedge Clk);
        n_checks++;
        if ({AluOp, Immediate, RaddrB, BranchOffset, RegWrEn, PcEn, BranchTaken, Halted,
             IllegalOp, InstrReady} !== 23'd1) begin
            n_fail++;
            $display("FAIL reset values: alu %0h imm %0h rb %0h off %0h strobes %b%b%b flags %b%b rdy %b, want all 0 rdy 1",
                     AluOp, Immediate, RaddrB, BranchOffset, RegWrEn, PcEn, BranchTaken,
                     Halted, IllegalOp, InstrReady);
        end
        // ADD #5 presented while releasing reset: must be taken on the very next edge
        Reset = 1'b0; Instruction = 9'b0_0000_0101; InstrValid = 1'b1;
        @(posedge Clk); #1;
        InstrValid = 1'b0;
        @(negedge Clk);
        n_checks++;
        if (InstrReady !== 1'b0) begin
            n_fail++;
            $display("FAIL first accept: ready in cycle 2 got %b want 0", InstrReady);
        end
        @(negedge Clk);
        n_checks++;
        if ({AluOp, Immediate, RegWrEn, PcEn} !== {4'd0, 5'd5, 2'b00}) begin
            n_fail++;
            $display("FAIL add5 exec: alu %0h imm %0h strobes %b%b want 0/5/00",
                     AluOp, Immediate, RegWrEn, PcEn);
        end
        @(negedge Clk);
        n_checks++;
        if ({RegWrEn, PcEn, BranchTaken} !== 3'b110) begin
            n_fail++;
            $display("FAIL add5 wb: regwr/pcen/taken got %b want 110", {RegWrEn, PcEn, BranchTaken});
        end
        @(negedge Clk);
        n_checks++;
        if ({InstrReady, RegWrEn, PcEn} !== 3'b100) begin
            n_fail++;
            $display("FAIL add5 cycle5: ready/regwr/pcen got %b want 100", {InstrReady, RegWrEn, PcEn});
        end
    endtask

    task automatic test_alu_ops();
        for (int op = 0; op < 7; op++) begin
            run_instr({op[3:0], 5'($urandom)}, 1'($urandom), "alu");
        end
    endtask

    task automatic test_bnz();
        run_instr(9'b0111_11101, 1'b0, "bnz_nz");
        run_instr(9'b0111_11101, 1'b1, "bnz_z");
    endtask

    task automatic test_idle();
        InstrValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            Instruction = 9'($urandom);
            @(negedge Clk);
            n_checks++;
            if ({InstrReady, RegWrEn, PcEn, BranchTaken, Halted, IllegalOp} !== 6'b100000) begin
                n_fail++;
                $display("FAIL idle cycle %0d: ready/strobes/flags got %b want 100000", i,
                         {InstrReady, RegWrEn, PcEn, BranchTaken, Halted, IllegalOp});
            end
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [8:0] list [6];
        int k = 0, cyc = 0, last = 0, n_wr = 0, n_pc = 0, exp_wr = 0;
        for (int i = 0; i < 6; i++) begin
            list[i] = {4'($urandom_range(0, 7)), 5'($urandom)};
            if (list[i][8:5] != 4'd7) exp_wr++;
        end
        InstrValid = 1'b1;
        while (cyc < 60) begin
            @(negedge Clk);
            cyc++;
            n_wr += int'(RegWrEn);
            n_pc += int'(PcEn);
            Zero = 1'($urandom);
            if (InstrReady) begin
                if (k > 0) begin
                    n_checks++;
                    if (cyc - last != 4) begin
                        n_fail++;
                        $display("FAIL b2b spacing: got %0d cycles want 4", cyc - last);
                    end
                end
                last = cyc;
                if (k == 6) break;
                Instruction = list[k];
                k++;
            end else begin
                // Halt opcode on the bus while not ready: capturing it would stall everything
                Instruction = 9'h1E0;
            end
        end
        InstrValid = 1'b0;
        n_checks++;
        if (k != 6 || n_wr != exp_wr || n_pc != 6) begin
            n_fail++;
            $display("FAIL b2b totals: accepted %0d regwr %0d pcen %0d want 6 %0d 6", k, n_wr, n_pc, exp_wr);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_instr({4'($urandom_range(0, 7)), 5'($urandom)}, 1'($urandom), "rand");
        end
    endtask

    task automatic test_reset_mid();
        @(negedge Clk);
        Instruction = 9'b0011_00011; InstrValid = 1'b1;
        @(posedge Clk); #1;
        InstrValid = 1'b0;
        @(posedge Clk); #2;
        n_checks++;
        if ({AluOp, RaddrB} !== {4'd3, 3'd3}) begin
            n_fail++;
            $display("FAIL xor exec: alu %0h rb %0h want 3/3", AluOp, RaddrB);
        end
        Reset = 1'b1;
        #1;
        n_checks++;
        if ({AluOp, Immediate, RaddrB, RegWrEn, PcEn, BranchTaken, InstrReady} !== 16'd1) begin
            n_fail++;
            $display("FAIL async reset: alu %0h imm %0h rb %0h strobes %b%b%b rdy %b want 0/0/0/000/1",
                     AluOp, Immediate, RaddrB, RegWrEn, PcEn, BranchTaken, InstrReady);
        end
        repeat (2) begin
            @(negedge Clk);
            n_checks++;
            if ({RegWrEn, PcEn} !== 2'b00) begin
                n_fail++;
                $display("FAIL aborted strobes: regwr/pcen got %b want 00", {RegWrEn, PcEn});
            end
        end
        Reset = 1'b0;
        @(negedge Clk);
        n_checks++;
        if ({InstrReady, RegWrEn, PcEn} !== 3'b100) begin
            n_fail++;
            $display("FAIL post-abort: ready/regwr/pcen got %b want 100", {InstrReady, RegWrEn, PcEn});
        end
        @(posedge Clk); #1;
        run_instr(9'b0000_00111, 1'b0, "post_abort");
    endtask

    task automatic test_stuck(input logic [8:0] ins, input logic halt, input string tag);
        @(negedge Clk);
        Instruction = ins; InstrValid = 1'b1;
        @(posedge Clk); #1;
        @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            Instruction = 9'($urandom);
            n_checks++;
            if ({Halted, IllegalOp, InstrReady, RegWrEn, PcEn, BranchTaken} !==
                {halt, ~halt, 4'b0000}) begin
                n_fail++;
                $display("FAIL %s stuck cycle %0d: halt/ill/rdy/strobes got %b want %b", tag, i,
                         {Halted, IllegalOp, InstrReady, RegWrEn, PcEn, BranchTaken},
                         {halt, ~halt, 4'b0000});
            end
        end
        #2 Reset = 1'b1;
        #1;
        n_checks++;
        if ({Halted, IllegalOp, InstrReady} !== 3'b001) begin
            n_fail++;
            $display("FAIL %s reset clear: halt/ill/rdy got %b want 001", tag, {Halted, IllegalOp, InstrReady});
        end
        InstrValid = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_bnz();
        test_idle();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_stuck({4'd15, 5'($urandom)}, 1'b1, "halt");
        test_stuck(9'b1001_00000, 1'b0, "illegal9");
        test_stuck({4'($urandom_range(8, 14)), 5'($urandom)}, 1'b0, "illegal_rand");
        run_instr(9'b0110_10101, 1'b0, "after_err");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
